// File: rtl/uart_pkg.sv
// Shared UART-side constants: field widths, command codes, response limits.
// Imported by the response encoder and its interface.
package uart_pkg;

  localparam int CMDLENGTH = 3;
  localparam int IRLENGTH  = 5;

  localparam int RESP_MAX_BYTES = 6;

  localparam logic [CMDLENGTH-1:0] CMD_NOP   = 3'd0;
  localparam logic [CMDLENGTH-1:0] CMD_READ  = 3'd1;
  localparam logic [CMDLENGTH-1:0] CMD_WRITE = 3'd2;
  localparam logic [CMDLENGTH-1:0] CMD_STAT  = 3'd3;
  localparam logic [CMDLENGTH-1:0] CMD_RST   = 3'd4;

endpackage

// File: rtl/response_encoder_if.sv
// Response request bus from the read arbiter plus the byte stream to the UART.
// master drives requests and tx ready; slave is the encoder.
interface response_encoder_if #(
  parameter int DATA_W = 8 * uart_pkg::RESP_MAX_BYTES
);
  import uart_pkg::*;

  logic                 RESP_VALID_I;
  logic                 RESP_READY_O;
  logic [CMDLENGTH-1:0] RESP_CMD_I;
  logic [IRLENGTH-1:0]  RESP_ADDR_I;
  logic [DATA_W-1:0]    RESP_DATA_I;
  logic [3:0]           RESP_NBYTES_I;

  logic                 TX_VALID_O;
  logic                 TX_READY_I;
  logic [7:0]           TX_DATA_O;

  modport master (
    output RESP_VALID_I,
    output RESP_CMD_I,
    output RESP_ADDR_I,
    output RESP_DATA_I,
    output RESP_NBYTES_I,
    input  RESP_READY_O,
    input  TX_VALID_O,
    input  TX_DATA_O,
    output TX_READY_I
  );

  modport slave (
    input  RESP_VALID_I,
    input  RESP_CMD_I,
    input  RESP_ADDR_I,
    input  RESP_DATA_I,
    input  RESP_NBYTES_I,
    output RESP_READY_O,
    output TX_VALID_O,
    output TX_DATA_O,
    input  TX_READY_I
  );

endinterface

// File: rtl/response_encoder.sv
// Serialises one response as a header byte followed by up to MAX_BYTES
// payload bytes, LSB byte first, over a valid/ready byte stream.
module response_encoder
  import uart_pkg::*;
#(
  parameter int MAX_BYTES = RESP_MAX_BYTES,
  parameter int DATA_W    = 8 * MAX_BYTES
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  response_encoder_if.slave bus,
  output logic          BUSY_O
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [7:0]        hdr_q;
  logic [DATA_W-1:0] sh_q;
  logic [3:0]        cnt_q;
  logic [3:0]        nbytes_c;
  logic              load;
  logic              shift;

  // Oversized byte counts are silently clamped to the payload capacity.
  always_comb begin
    nbytes_c = bus.RESP_NBYTES_I;
    if (bus.RESP_NBYTES_I > 4'(MAX_BYTES))
      nbytes_c = 4'(MAX_BYTES);
  end

  // State register.
  always_ff @(posedge CLK_I) begin
    if (RST_I)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  // Next state, handshakes and output byte select (registers only).
  always_comb begin
    state_d          = state_q;
    load             = 1'b0;
    shift            = 1'b0;
    bus.RESP_READY_O = 1'b0;
    bus.TX_VALID_O   = 1'b0;
    bus.TX_DATA_O    = 8'h00;
    BUSY_O           = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        bus.RESP_READY_O = 1'b1;
        BUSY_O           = 1'b0;
        if (bus.RESP_VALID_I) begin
          load    = 1'b1;
          state_d = ST_HEADER;
        end
      end
      ST_HEADER: begin
        bus.TX_VALID_O = 1'b1;
        bus.TX_DATA_O  = hdr_q;
        if (bus.TX_READY_I)
          state_d = (cnt_q == 4'd0) ? ST_IDLE : ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        bus.TX_VALID_O = 1'b1;
        bus.TX_DATA_O  = sh_q[7:0];
        if (bus.TX_READY_I) begin
          shift = 1'b1;
          if (cnt_q == 4'd1)
            state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Header latch, payload shifter and remaining-byte counter.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      hdr_q <= 8'h00;
      sh_q  <= '0;
      cnt_q <= 4'd0;
    end else if (load) begin
      hdr_q <= {bus.RESP_CMD_I, bus.RESP_ADDR_I};
      sh_q  <= bus.RESP_DATA_I;
      cnt_q <= nbytes_c;
    end else if (shift) begin
      sh_q  <= sh_q >> 8;
      cnt_q <= cnt_q - 4'd1;
    end
  end

endmodule

// File: tb/tb_response_encoder.sv
// Bench for response_encoder: directed scenarios plus random traffic,
// checked against a byte-queue model of each response.
module tb_response_encoder;
  import uart_pkg::*;

  localparam int MB = RESP_MAX_BYTES;
  localparam int DW = 8 * MB;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  int checks   = 0;
  int failures = 0;
  int xfers    = 0;

  logic [7:0] exp_q[$];

  response_encoder_if #(.DATA_W(DW)) bus();

  response_encoder #(
    .MAX_BYTES(MB),
    .DATA_W(DW)
  ) dut (
    .CLK_I(clk),
    .RST_I(rst),
    .bus(bus.slave),
    .BUSY_O(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic                 v,
                     input logic [CMDLENGTH-1:0] c,
                     input logic [IRLENGTH-1:0]  a,
                     input logic [DW-1:0]        d,
                     input logic [3:0]           n,
                     input logic                 tr,
                     input logic                 r);
    int nb;
    bus.RESP_VALID_I  = v;
    bus.RESP_CMD_I    = c;
    bus.RESP_ADDR_I   = a;
    bus.RESP_DATA_I   = d;
    bus.RESP_NBYTES_I = n;
    bus.TX_READY_I    = tr;
    rst               = r;
    #1;
    chk("resp_ready", 64'(bus.RESP_READY_O), 64'(exp_q.size() == 0));
    chk("tx_valid", 64'(bus.TX_VALID_O), 64'(exp_q.size() != 0));
    chk("busy", 64'(busy), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0)
      chk("tx_data", 64'(bus.TX_DATA_O), 64'(exp_q[0]));
    if (r) begin
      exp_q.delete();
    end else if (exp_q.size() == 0 && v) begin
      nb = (int'(n) > MB) ? MB : int'(n);
      exp_q.push_back({c, a});
      for (int i = 0; i < nb; i++)
        exp_q.push_back(d[8*i +: 8]);
    end else if (exp_q.size() != 0 && tr) begin
      void'(exp_q.pop_front());
      xfers++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k, input logic tr);
    for (int i = 0; i < k; i++)
      cyc(1'b0, '0, '0, '0, 4'd0, tr, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] rd;
    bus.RESP_VALID_I  = 1'b0;
    bus.RESP_CMD_I    = '0;
    bus.RESP_ADDR_I   = '0;
    bus.RESP_DATA_I   = '0;
    bus.RESP_NBYTES_I = '0;
    bus.TX_READY_I    = 1'b0;
    rst               = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_tx_data", 64'(bus.TX_DATA_O), 64'h00);
    cyc(1'b0, '0, '0, '0, 4'd0, 1'b0, 1'b1);

    xfers = 0;
    cyc(1'b1, CMD_READ, 5'h11, '0, 4'd0, 1'b1, 1'b0);
    idle(3, 1'b1);
    chk("hdr_only_xfers", 64'(xfers), 64'd1);

    xfers = 0;
    cyc(1'b1, CMD_WRITE, 5'h05, 48'h0A_1234_5678_9B, 4'd6, 1'b1, 1'b0);
    idle(7, 1'b1);
    chk("full_xfers", 64'(xfers), 64'd7);
    idle(2, 1'b1);

    xfers = 0;
    cyc(1'b1, CMD_STAT, 5'h1F, 48'hFF_EEDD_CCBB_AA, 4'd4, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++)
      cyc(1'b0, '0, '0, '0, 4'd0, 1'(i % 2), 1'b0);
    chk("bp_xfers", 64'(xfers), 64'd5);

    xfers = 0;
    cyc(1'b1, 3'd7, 5'h0C, 48'h665544332211, 4'd15, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++)
      cyc(1'b1, CMD_RST, 5'h03, 48'hDEADBEEF0000, 4'd2, 1'b1, 1'b0);
    idle(2, 1'b1);
    chk("clamp_xfers", 64'(xfers), 64'd7);

    xfers = 0;
    cyc(1'b1, CMD_READ, 5'h0A, 48'h060504030201, 4'd6, 1'b1, 1'b0);
    idle(3, 1'b1);
    cyc(1'b0, '0, '0, '0, 4'd0, 1'b1, 1'b1);
    chk("rst_mid_ready", 64'(bus.RESP_READY_O), 64'd1);
    chk("rst_mid_valid", 64'(bus.TX_VALID_O), 64'd0);
    cyc(1'b1, CMD_WRITE, 5'h15, 48'h0000000000AB, 4'd1, 1'b1, 1'b0);
    idle(3, 1'b1);

    for (int i = 0; i < 2000; i++) begin
      rd = {16'($urandom), $urandom};
      cyc(1'($urandom_range(0, 3) == 0),
          3'($urandom), 5'($urandom), rd,
          4'($urandom_range(0, 15)),
          1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 80) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
